// File: rtl/omer_pkg.sv
// Shared types and constants for the kamus fetch stage.
package omer_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch result as seen by decode.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    // Clear the byte offset so the address points at a whole word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/kamus_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a one-cycle flush.
module kamus_fetch_fifo
    import omer_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // Advance pointers and store pushed entries; flush drops everything at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PTR_W-1:0]] <= push_data;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kamus_fetch.sv
// Instruction fetch stage: owns the PC, talks req/gnt/rvalid to instruction
// memory, buffers returned words and hands them to decode with valid/ready.
module kamus_fetch
    import omer_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fetch_err_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      fault_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic             started;
    logic             fault_pending;
    logic             stalled;
    logic             fifo_full;
    logic             fifo_empty;
    logic             can_issue;
    logic             req_fire;
    logic             resp_fire;
    logic             accept_resp;
    logic             fault_push;
    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Room must exist for every in-flight word, so a response never meets a full buffer.
    assign can_issue = (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH)
                    && (int'(outstanding) < MAX_OUTSTANDING) && !fifo_full;
    assign imem_req_o  = !rst_i && started && !redirect_i && !fault_pending
                      && !stalled && can_issue;
    assign imem_addr_o = fetch_pc;

    // Responses with nothing in flight (e.g. leftovers from before a reset) are ignored.
    assign req_fire         = imem_req_o && imem_gnt_i;
    assign resp_fire        = imem_rvalid_i && (outstanding != '0);
    assign accept_resp      = resp_fire && (discard == '0);
    assign fault_push       = fault_pending && (discard == '0);
    assign fifo_push        = !redirect_i && (accept_resp || fault_push);
    assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);

    // Choose what goes into the buffer: a misalign fault, a bus-error NOP, or the fetched word.
    always_comb begin
        push_entry = '{instr: imem_rdata_i, pc: resp_pc, err: 1'b0};
        if (fault_push) begin
            push_entry = '{instr: NOP_INSTR, pc: fault_pc, err: 1'b1};
        end else if (imem_err_i) begin
            push_entry = '{instr: NOP_INSTR, pc: resp_pc, err: 1'b1};
        end
    end

    kamus_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (redirect_i),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .head     (head_entry),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign instr_valid_o = !rst_i && !fifo_empty;
    assign fifo_pop      = instr_valid_o && instr_ready_i;
    assign instr_o       = instr_valid_o ? head_entry.instr : '0;
    assign pc_o          = instr_valid_o ? head_entry.pc    : '0;
    assign fetch_err_o   = instr_valid_o ? head_entry.err   : 1'b0;

    // Track PCs, in-flight requests and stale-response discards; a redirect overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc      <= RESET_PC;
            resp_pc       <= RESET_PC;
            fault_pc      <= '0;
            outstanding   <= '0;
            discard       <= '0;
            started       <= 1'b0;
            fault_pending <= 1'b0;
            stalled       <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect_i) begin
                fetch_pc      <= align_word(redirect_pc_i);
                resp_pc       <= align_word(redirect_pc_i);
                fault_pc      <= redirect_pc_i;
                discard       <= outstanding_next;
                fault_pending <= (redirect_pc_i[1:0] != 2'b00);
                stalled       <= 1'b0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_fire) begin
                    if (discard != '0) begin
                        discard <= discard - 1'b1;
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
                if (fault_push) begin
                    fault_pending <= 1'b0;
                    stalled       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kamus_fetch.sv
// Scoreboard bench for kamus_fetch: a randomized memory model answers requests,
// the expected decode stream is queued whenever a reset or redirect is issued,
// and a monitor compares every accepted instruction against that queue.
module tb_kamus_fetch;
    import omer_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fetch_err_o;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          delivered    = 0;
    int unsigned cyc          = 0;
    int unsigned lat_min      = 1;
    int unsigned lat_max      = 1;
    int unsigned gnt_pct      = 100;
    logic        err_enable    = 1'b0;
    logic        stall_expected = 1'b0;
    logic        stray_pending  = 1'b0;
    logic [31:0] exp_grant_addr = RESET_PC;
    fetch_entry_t exp_q[$];
    pend_t        pend[$];

    kamus_fetch #(
        .RESET_PC(RESET_PC), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents are a fixed scramble of the address, so any word is predictable.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Bus errors hit every address whose word index within a 64-byte block is 2 (0x8, 0x48, ...).
    function automatic logic is_err(input logic [31:0] a);
        return err_enable && (a[5:2] == 4'd2);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Queue the sequential stream decode must see after fetch restarts at base.
    task automatic fill_stream(input logic [31:0] base);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{instr: is_err(a) ? NOP_INSTR : mem_data(a), pc: a, err: is_err(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_req"},   imem_req_o,    0);
        check_output({tag, "_valid"}, instr_valid_o, 0);
        check_output({tag, "_err"},   fetch_err_o,   0);
        check_output({tag, "_instr"}, instr_o,       0);
        check_output({tag, "_pc"},    pc_o,          0);
    endtask

    // Reset for several cycles, then release with a stray response that must be ignored.
    task automatic apply_reset(input int cycles);
        rst_i = 1'b1;
        redirect_i = 1'b0;
        instr_ready_i = 1'b0;
        exp_q.delete();
        fill_stream(RESET_PC);
        exp_grant_addr = RESET_PC;
        stall_expected = 1'b0;
        repeat (cycles) tick();
        @(negedge clk_i);
        check_idle_outputs("in_reset");
        @(posedge clk_i);
        #1;
        stray_pending = 1'b1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("after_reset");
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle redirect; decode is held off so no old entry is consumed in this cycle.
    task automatic apply_redirect(input logic [31:0] target);
        instr_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = target;
        exp_q.delete();
        if (target[1:0] != 2'b00) begin
            exp_q.push_back('{instr: NOP_INSTR, pc: target, err: 1'b1});
            stall_expected = 1'b1;
        end else begin
            fill_stream(target);
            stall_expected = 1'b0;
        end
        exp_grant_addr = {target[31:2], 2'b00};
        tick();
        redirect_i = 1'b0;
    endtask

    task automatic run_cycles(input int n, input logic ready);
        instr_ready_i = ready;
        repeat (n) tick();
    endtask

    // Memory model: random grants, in-order responses after a random latency.
    initial begin
        pend_t p;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        imem_err_i = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                pend.delete();
                imem_gnt_i = 1'b0;
                imem_rvalid_i = 1'b0;
            end else begin
                if (redirect_i) check_output("req_in_redirect", imem_req_o, 0);
                if (stall_expected) check_output("req_in_stall", imem_req_o, 0);
                imem_gnt_i = ($urandom_range(99) < gnt_pct);
                if (imem_req_o && imem_gnt_i) begin
                    check_output("grant_addr", imem_addr_o, exp_grant_addr);
                    exp_grant_addr = exp_grant_addr + 32'd4;
                    p.addr = imem_addr_o;
                    p.due = cyc + $urandom_range(lat_max, lat_min);
                    pend.push_back(p);
                end
                if (stray_pending) begin
                    stray_pending = 1'b0;
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i = 32'hDEAD_BEEF;
                    imem_err_i = 1'b1;
                end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                    p = pend.pop_front();
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i = mem_data(p.addr);
                    imem_err_i = is_err(p.addr);
                end else begin
                    imem_rvalid_i = 1'b0;
                    imem_rdata_i = $urandom;
                    imem_err_i = 1'($urandom_range(1));
                end
            end
        end
    end

    // Monitor: every accepted instruction must be the next one the model expects.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && instr_valid_o && instr_ready_i) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_output: got pc %h, expected no entry", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check_output("pc", pc_o, e.pc);
                    check_output("instr", instr_o, e.instr);
                    check_output("fetch_err", fetch_err_o, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish within bound");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          base;
        logic [31:0] t;
        int          since;
        rst_i = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;

        // Straight-line fetch from reset with one-cycle memory.
        apply_reset(2);
        run_cycles(20, 1'b1);
        check_output("initial_progress", (delivered >= 5), 1);

        // Decode stalls: buffer fills and requests stop, then drain resumes.
        run_cycles(10, 1'b0);
        @(negedge clk_i);
        check_output("stall_req_dropped", imem_req_o, 0);
        check_output("stall_buffered", instr_valid_o, 1);
        base = delivered;
        tick();
        run_cycles(10, 1'b1);
        check_output("drain_resumed", (delivered >= base + 3), 1);

        // Redirect with slow memory so stale responses are in flight.
        lat_min = 4; lat_max = 4;
        run_cycles(8, 1'b1);
        apply_redirect(32'h0000_0100);
        lat_min = 1; lat_max = 1;
        base = delivered;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 40 && delivered < base + 3; i++) tick();
        check_output("progress_after_redirect", (delivered >= base + 3), 1);

        // Bus error on the word at 0x8, fetch continues at 0xC.
        err_enable = 1'b1;
        apply_redirect(32'h0000_0000);
        run_cycles(20, 1'b1);

        // Misaligned target: one fault entry, then a stall until the next redirect.
        lat_min = 1; lat_max = 3;
        run_cycles(3, 1'b1);
        apply_redirect(32'h0000_0102);
        run_cycles(20, 1'b1);
        check_output("misalign_entry_consumed", exp_q.size(), 0);

        // Sequential fetch across the top of the address space.
        apply_redirect(32'hFFFF_FFF8);
        run_cycles(20, 1'b1);

        // Reset in the middle of traffic; old responses must not leak through.
        lat_min = 2; lat_max = 3;
        run_cycles(5, 1'b1);
        apply_reset(1);
        run_cycles(20, 1'b1);

        // Randomized traffic with random stalls, grants, latencies and redirects.
        gnt_pct = 70;
        since = 0;
        for (int c = 0; c < 600; c++) begin
            if (since >= 80 || $urandom_range(24) == 0) begin
                t = $urandom;
                if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0;
                if ($urandom_range(5) == 0) t[1:0] = 2'($urandom_range(3, 1));
                else t[1:0] = 2'b00;
                apply_redirect(t);
                since = 0;
            end else begin
                instr_ready_i = ($urandom_range(3) != 0);
                tick();
                since++;
            end
        end
        run_cycles(20, 1'b1);
        check_output("random_progress", (delivered > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
